// File: rtl/bloom_filter_sched.sv
// bloom_filter_sched: two-requester round-robin sequencer in front of a single
// Bloom filter. It issues one probe/insert/delete at a time, waits out the
// filter latency, returns a tagged response, sequences full clears and keeps
// a saturating element count.
module bloom_filter_sched #(
   parameter int AddrW       = 57,
   parameter int TagW        = 4,
   parameter int Latency     = 2,
   parameter int ClearCycles = 4,
   parameter int CountW      = 16
) (
   input  logic              CLK,
   input  logic              rstb,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [1:0]        req0_op,
   input  logic [AddrW-1:0]  req0_addr,
   input  logic [TagW-1:0]   req0_tag,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [1:0]        req1_op,
   input  logic [AddrW-1:0]  req1_addr,
   input  logic [TagW-1:0]   req1_tag,
   input  logic              clr_req,
   output logic              clr_done,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_src,
   output logic [TagW-1:0]   resp_tag,
   output logic [1:0]        resp_op,
   output logic              resp_hit,
   output logic [AddrW-1:0]  bf_Addr,
   output logic              bf_WE,
   output logic              bf_increment,
   output logic              bf_rst_n,
   input  logic              bf_result,
   output logic [CountW-1:0] elem_count,
   output logic              busy
);

   // One down-counter serves both the filter-latency wait and the clear hold.
   localparam int CntMax = (Latency > ClearCycles) ? Latency : ClearCycles;
   localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

   localparam logic [1:0] OP_INSERT = 2'b01;
   localparam logic [1:0] OP_DELETE = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_CLEAR} state_t;

   state_t              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [1:0]          op_q, op_d;
   logic [AddrW-1:0]    addr_q, addr_d;
   logic [TagW-1:0]     tag_q, tag_d;
   logic                src_q, src_d;
   logic                last_q, last_d;
   logic                hit_q, hit_d;
   logic [CountW-1:0]   count_q, count_d;
   logic                bf_we_q, bf_we_d;
   logic                bf_inc_q, bf_inc_d;
   logic                bf_rst_n_q, bf_rst_n_d;
   logic                clr_done_q, clr_done_d;
   logic                resp_valid_q, resp_valid_d;
   logic                busy_q, busy_d;

   logic                any_valid;
   logic                grant_sel;
   logic                accept;

   // Insert count saturates at all-ones instead of wrapping.
   function automatic logic [CountW-1:0] sat_inc(input logic [CountW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Delete count floors at zero instead of wrapping.
   function automatic logic [CountW-1:0] floor_dec(input logic [CountW-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   // Round-robin grant: on a tie the requester not served last time wins.
   // A clear request or a pending reset suppresses every grant.
   assign any_valid  = req0_valid | req1_valid;
   assign grant_sel  = (req0_valid & req1_valid) ? ~last_q : req1_valid;
   assign accept     = (state_q == S_IDLE) & ~clr_req & any_valid & ~rstb;
   assign req0_ready = accept & ~grant_sel;
   assign req1_ready = accept & grant_sel;

   assign clr_done     = clr_done_q;
   assign resp_valid   = resp_valid_q;
   assign resp_src     = src_q;
   assign resp_tag     = tag_q;
   assign resp_op      = op_q;
   assign resp_hit     = hit_q;
   assign bf_Addr      = addr_q;
   assign bf_WE        = bf_we_q;
   assign bf_increment = bf_inc_q;
   assign bf_rst_n     = bf_rst_n_q;
   assign elem_count   = count_q;
   assign busy         = busy_q;

   // Next-state, datapath capture and registered-output decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      addr_d   = addr_q;
      tag_d    = tag_q;
      src_d    = src_q;
      last_d   = last_q;
      hit_d    = hit_q;
      count_d  = count_q;

      case (state_q)
         S_IDLE: begin
            if (clr_req) begin
               state_d = S_CLEAR;
               cnt_d   = CntW'(ClearCycles - 1);
               count_d = '0;
            end else if (accept) begin
               state_d = S_ISSUE;
               op_d    = grant_sel ? req1_op   : req0_op;
               addr_d  = grant_sel ? req1_addr : req0_addr;
               tag_d   = grant_sel ? req1_tag  : req0_tag;
               src_d   = grant_sel;
               last_d  = grant_sel;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            cnt_d   = CntW'(Latency - 1);
            if (op_q == OP_INSERT) begin
               count_d = sat_inc(count_q);
            end else if (op_q == OP_DELETE) begin
               count_d = floor_dec(count_q);
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               hit_d   = bf_result;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they appear registered.
      bf_we_d      = (state_d == S_ISSUE) && ((op_d == OP_INSERT) || (op_d == OP_DELETE));
      bf_inc_d     = (state_d == S_ISSUE) && (op_d == OP_INSERT);
      bf_rst_n_d   = (state_d != S_CLEAR);
      clr_done_d   = (state_q == S_CLEAR) && (cnt_q == '0);
      resp_valid_d = (state_d == S_RESP);
      busy_d       = (state_d != S_IDLE);
   end

   // Single state/output register; reset drops any in-flight work.
   always_ff @(posedge CLK) begin
      if (rstb) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         op_q         <= '0;
         addr_q       <= '0;
         tag_q        <= '0;
         src_q        <= 1'b0;
         last_q       <= 1'b1;
         hit_q        <= 1'b0;
         count_q      <= '0;
         bf_we_q      <= 1'b0;
         bf_inc_q     <= 1'b0;
         bf_rst_n_q   <= 1'b0;
         clr_done_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         tag_q        <= tag_d;
         src_q        <= src_d;
         last_q       <= last_d;
         hit_q        <= hit_d;
         count_q      <= count_d;
         bf_we_q      <= bf_we_d;
         bf_inc_q     <= bf_inc_d;
         bf_rst_n_q   <= bf_rst_n_d;
         clr_done_q   <= clr_done_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

endmodule

// File: tb/tb_bloom_filter_sched.sv
// Testbench for bloom_filter_sched: directed scenarios plus a randomized run,
// with a set-membership reference model and a response scoreboard.
module tb_bloom_filter_sched;

   localparam int AW   = 57;
   localparam int TW   = 4;
   localparam int LAT  = 2;
   localparam int CLR  = 4;
   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          CLK = 1'b0;
   logic          rstb;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]    req0_op, req1_op;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [TW-1:0] req0_tag, req1_tag;
   logic          clr_req, clr_done;
   logic          resp_valid, resp_ready, resp_src, resp_hit;
   logic [TW-1:0] resp_tag;
   logic [1:0]    resp_op;
   logic [AW-1:0] bf_Addr;
   logic          bf_WE, bf_increment, bf_rst_n;
   logic          bf_result = 1'b0;
   logic [CW-1:0] elem_count;
   logic          busy;

   always #5 CLK = ~CLK;

   bloom_filter_sched #(
      .AddrW(AW), .TagW(TW), .Latency(LAT), .ClearCycles(CLR), .CountW(CW)
   ) dut (
      .CLK(CLK), .rstb(rstb),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_addr(req0_addr), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_addr(req1_addr), .req1_tag(req1_tag),
      .clr_req(clr_req), .clr_done(clr_done),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_src(resp_src),
      .resp_tag(resp_tag), .resp_op(resp_op), .resp_hit(resp_hit),
      .bf_Addr(bf_Addr), .bf_WE(bf_WE), .bf_increment(bf_increment),
      .bf_rst_n(bf_rst_n), .bf_result(bf_result),
      .elem_count(elem_count), .busy(busy)
   );

   typedef struct {
      bit          src;
      bit [TW-1:0] tag;
      bit [1:0]    op;
      bit          hit;
      int          cnt;
      int          acc;
   } exp_t;

   exp_t sbq[$];
   int   gseq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   // Reference model state: per-address membership counts and element total.
   int            ref_cnt [logic [AW-1:0]];
   int            ref_elems;
   bit            last_g;
   int            idle_from, last_acc, clr_start;
   bit [1:0]      last_op;
   logic [AW-1:0] last_addr;

   // Stimulus state for both requesters.
   bit            pv [2];
   bit [1:0]      pop [2];
   logic [AW-1:0] paddr [2];
   bit [TW-1:0]   ptag [2];
   bit            clr_in, rr_in;
   logic [AW-1:0] pool [6];

   // Stand-in counting filter: exact per-address counts, cleared by bf_rst_n.
   int fcount [logic [AW-1:0]];

   always @(posedge CLK) cyc = cyc + 1;

   always @(posedge CLK) begin : filt
      int c;
      if (bf_rst_n !== 1'b1) fcount.delete();
      else if (bf_WE === 1'b1) begin
         c = fcount.exists(bf_Addr) ? fcount[bf_Addr] : 0;
         if (bf_increment) c = c + 1;
         else if (c > 0) c = c - 1;
         fcount[bf_Addr] = c;
      end
   end

   always @(negedge CLK)
      bf_result = fcount.exists(bf_Addr) && (fcount[bf_Addr] > 0);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Spec-level effect of one operation on the set; returns membership after it.
   function automatic bit predict(input bit [1:0] op, input logic [AW-1:0] a);
      int c;
      c = ref_cnt.exists(a) ? ref_cnt[a] : 0;
      if (op == 2'b01) begin
         c++;
         ref_elems = (ref_elems == MAXC) ? MAXC : ref_elems + 1;
      end else if (op == 2'b10) begin
         if (c > 0) c--;
         ref_elems = (ref_elems == 0) ? 0 : ref_elems - 1;
      end
      ref_cnt[a] = c;
      return c > 0;
   endfunction

   task automatic set_req(input int i, input bit [1:0] op, input logic [AW-1:0] a, input bit [TW-1:0] t);
      pv[i] = 1'b1; pop[i] = op; paddr[i] = a; ptag[i] = t;
   endtask

   task automatic new_req(input int i);
      int r;
      bit [1:0] op;
      r = $urandom_range(0, 9);
      op = (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
      set_req(i, op, pool[$urandom_range(0, 5)], TW'($urandom));
   endtask

   // One clock of stimulus plus all per-cycle expectations.
   task automatic step(input int pct);
      bit   idle, acc, sel;
      exp_t e;
      @(negedge CLK);
      for (int i = 0; i < 2; i++)
         if (!pv[i] && $urandom_range(0, 99) < pct) new_req(i);
      req0_valid = pv[0]; req0_op = pop[0]; req0_addr = paddr[0]; req0_tag = ptag[0];
      req1_valid = pv[1]; req1_op = pop[1]; req1_addr = paddr[1]; req1_tag = ptag[1];
      clr_req = clr_in;
      resp_ready = rr_in;
      #1;
      idle = (cyc >= idle_from);
      acc  = idle && !clr_in && (pv[0] || pv[1]);
      sel  = (pv[0] && pv[1]) ? !last_g : pv[1];
      chk("req0_ready", req0_ready, acc && !sel);
      chk("req1_ready", req1_ready, acc && sel);
      chk("busy", busy, !idle);
      chk("bf_WE", bf_WE, (cyc == last_acc + 1) && (last_op == 2'b01 || last_op == 2'b10));
      chk("bf_increment", bf_increment, (cyc == last_acc + 1) && (last_op == 2'b01));
      if (cyc == last_acc + 1) chk("bf_Addr", bf_Addr, last_addr);
      chk("bf_rst_n", bf_rst_n, !(cyc > clr_start && cyc <= clr_start + CLR));
      chk("clr_done", clr_done, cyc == clr_start + CLR + 1);
      if (cyc == clr_start + CLR + 1) chk("elem_count_after_clear", elem_count, 0);
      if (idle && clr_in) begin
         clr_start = cyc;
         idle_from = cyc + CLR + 1;
         ref_cnt.delete();
         ref_elems = 0;
      end else if (acc) begin
         e.src = sel; e.tag = ptag[sel]; e.op = pop[sel];
         e.hit = predict(pop[sel], paddr[sel]);
         e.cnt = ref_elems; e.acc = cyc;
         sbq.push_back(e);
         idle_from = 1 << 30;
         last_g = sel; last_acc = cyc; last_op = pop[sel]; last_addr = paddr[sel];
         gseq.push_back(int'(sel));
         pv[sel] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      rstb = 1'b1;
      req0_valid = 0; req1_valid = 0; clr_req = 0; resp_ready = 0;
      pv[0] = 0; pv[1] = 0; clr_in = 0;
      @(negedge CLK);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_bf_WE", bf_WE, 0);
      chk("rst_bf_increment", bf_increment, 0);
      chk("rst_bf_rst_n", bf_rst_n, 0);
      chk("rst_clr_done", clr_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_elem_count", elem_count, 0);
      chk("rst_resp_hit", resp_hit, 0);
      chk("rst_bf_Addr", bf_Addr, 0);
      sbq.delete();
      ref_cnt.delete();
      ref_elems = 0;
      last_g = 1'b1;
      idle_from = cyc;
      last_acc = -10;
      clr_start = -100;
      rstb = 1'b0;
   endtask

   task automatic run_one(input bit [1:0] op, input logic [AW-1:0] a, input bit [TW-1:0] t);
      set_req(0, op, a, t);
      repeat (6) step(0);
   endtask

   // Scoreboard monitor: compares every cycle a response is presented.
   initial begin : monitor
      bit   held = 1'b0;
      exp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (resp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("resp_unexpected", resp_valid, 0);
            end else begin
               e = sbq[0];
               if (!held) chk("resp_latency", cyc - e.acc, 2 + LAT);
               chk("resp_src", resp_src, e.src);
               chk("resp_tag", resp_tag, e.tag);
               chk("resp_op", resp_op, e.op);
               chk("resp_hit", resp_hit, e.hit);
               chk("elem_count", elem_count, e.cnt);
               if (resp_ready === 1'b1) begin
                  void'(sbq.pop_front());
                  idle_from = cyc + 1;
               end
            end
         end
         held = (resp_valid === 1'b1) && (resp_ready !== 1'b1);
      end
   end

   initial begin
      rstb = 1'b1;
      req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
      req0_addr = 0; req1_addr = 0; req0_tag = 0; req1_tag = 0;
      clr_req = 0; resp_ready = 0; clr_in = 0; rr_in = 1;
      pool[0] = 57'h5000; pool[1] = 57'h7000; pool[2] = 57'h8000;
      pool[3] = 57'h1FF_FFFF_FFFF_FFFF; pool[4] = 57'h0; pool[5] = 57'h123_4567_89AB;
      do_reset();

      // Insert then probe the same address.
      rr_in = 1;
      run_one(2'b01, 57'h5000, 4'd3);
      run_one(2'b00, 57'h5000, 4'd4);
      chk("tp_insert_probe_count", elem_count, 1);

      // Continuous tie after reset: grants alternate starting with req0.
      do_reset();
      gseq.delete();
      repeat (30) step(100);
      chk("rr_grant_count", gseq.size() >= 4, 1);
      if (gseq.size() >= 4)
         for (int k = 0; k < 4; k++) chk("rr_grant_order", gseq[k], k % 2);
      repeat (12) step(0);

      // Response backpressure with a second requester waiting.
      set_req(0, 2'b01, 57'h6000, 4'd5);
      set_req(1, 2'b00, 57'h6000, 4'd6);
      rr_in = 0;
      repeat (14) step(0);
      rr_in = 1;
      repeat (12) step(0);

      // Delete path including delete at zero count.
      do_reset();
      run_one(2'b01, 57'h7000, 4'd1);
      run_one(2'b10, 57'h7000, 4'd2);
      run_one(2'b00, 57'h7000, 4'd3);
      run_one(2'b10, 57'h7000, 4'd4);
      chk("delete_floor_count", elem_count, 0);

      // Clear wins over a simultaneous request.
      run_one(2'b01, 57'h8000, 4'd7);
      set_req(0, 2'b00, 57'h8000, 4'd8);
      clr_in = 1;
      step(0);
      clr_in = 0;
      repeat (12) step(0);

      // Reset while waiting on the filter drops the operation.
      set_req(0, 2'b01, 57'h9000, 4'd9);
      repeat (3) step(0);
      do_reset();
      repeat (8) step(0);

      // Randomized traffic, backpressure and occasional clears.
      for (int n = 0; n < 1500; n++) begin
         rr_in  = ($urandom_range(0, 3) != 0);
         clr_in = ($urandom_range(0, 299) == 0);
         step(50);
      end
      clr_in = 0;
      rr_in = 1;
      repeat (40) step(0);
      chk("scoreboard_empty", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bloom_filter_sched.md
Name: bloom_filter_sched

Overview:
- Sequencer and arbiter in front of one BloomFilter instance.
- Accepts probe, insert and delete requests from two requesters using round-robin arbitration.
- Drives the filter's Addr/WE/increment inputs, waits the filter's update latency, samples its result, and returns a tagged response.
- Also sequences a full filter clear and keeps a saturating count of inserted elements.

Parameters:
- AddrW, 57, request and filter address width
- TagW, 4, requester transaction tag width
- Latency, 2, cycles from issue until bf_result is valid for the issued address (minimum 1)
- ClearCycles, 4, cycles bf_rst_n is held low during a clear (minimum 1)
- CountW, 16, width of the element counter

Ports:
- CLK  in  1  clock
- rstb  in  1  reset; synchronous, active-high
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_op  in  2  00 probe, 01 insert, 10 delete, 11 reserved (treated as probe)
- req0_addr  in  AddrW  request address
- req0_tag  in  TagW  transaction tag
- req1_valid, req1_ready, req1_op, req1_addr, req1_tag  same meaning, requester 1
- clr_req  in  1  request a full filter clear
- clr_done  out  1  one-cycle pulse when the clear completes
- resp_valid  out  1  response available
- resp_ready  in  1  response consumer accepts
- resp_src  out  1  requester index of the response
- resp_tag  out  TagW  echoed tag
- resp_op  out  2  echoed op
- resp_hit  out  1  sampled bf_result
- bf_Addr  out  AddrW  to filter Addr
- bf_WE  out  1  to filter WE
- bf_increment  out  1  to filter increment
- bf_rst_n  out  1  to filter rstb (active low)
- bf_result  in  1  from filter result
- elem_count  out  CountW  saturating element count
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rstb=1 at a CLK edge) takes effect on the next edge and overrides everything:
  - State becomes IDLE.
  - All outputs are 0, except bf_rst_n, which is 0 while rstb=1 and 1 after reset.
  - elem_count becomes 0.
  - Round-robin pointer is set so req0 wins the first tie.
  - Any in-flight operation or response is dropped.
- States: IDLE, ISSUE, WAIT, RESP, CLEAR.
- IDLE:
  - If clr_req=1, go to CLEAR. Clear has priority over requests; no req ready is asserted that cycle.
  - Otherwise, if any reqN_valid=1, grant one requester:
    - If only one requester is valid, it is granted.
    - If both are valid, the requester not granted last time wins.
  - reqN_ready=1 combinationally, for the granted requester only.
  - On that edge, latch op, addr, tag and src, update the pointer, and go to ISSUE.
- ISSUE (1 cycle):
  - bf_Addr = latched addr.
  - bf_WE = 1 for insert or delete; 0 for probe.
  - bf_increment = 1 for insert only.
  - Go to WAIT with the wait counter set to Latency-1.
- WAIT:
  - bf_Addr held, bf_WE=0, bf_increment=0.
  - Counter decrements each cycle.
  - When the counter reaches 0: latch bf_result into resp_hit and go to RESP.
  - With Latency=1, WAIT lasts exactly 1 cycle.
- RESP:
  - resp_valid=1, with resp_src, resp_tag, resp_op and resp_hit stable.
  - Stays in RESP until resp_ready=1; on that edge, go to IDLE.
  - A new request cannot be granted in the same cycle as the response handshake.
  - Request-to-response latency is 2+Latency cycles (accept edge to resp_valid).
- elem_count:
  - Updated on the ISSUE edge.
  - Insert: +1, saturating at 2^CountW-1.
  - Delete: -1, held at 0 when already 0.
  - Probe: unchanged.
- CLEAR:
  - bf_rst_n=0 for ClearCycles cycles; elem_count is set to 0 on entry.
  - On exit, clr_done=1 for one cycle (the first IDLE cycle) and bf_rst_n returns to 1.
  - clr_req held high past completion starts another clear.
- clr_req outside IDLE is not latched; it must be held until serviced.
- Reserved op 11: behaves as probe; elem_count unchanged.
- busy = (state != IDLE).

Test Plan:
- Insert, then probe: req0 insert addr 0x5000, tag 3, then req0 probe 0x5000, tag 4 (Latency=2) -> resp_valid rises 4 cycles after each accept; resp_hit=1 on probe; elem_count=1; bf_WE=1, bf_increment=1 for exactly 1 cycle on the insert only.
- Round-robin tie: req0 and req1 both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1; first grant after reset goes to req0; each ready is a one-cycle pulse.
- Response backpressure: resp_ready held 0 for 10 cycles -> resp_valid and fields stable throughout; no req ready asserted; IDLE re-entered the cycle after resp_ready=1.
- Delete path: insert 0x7000, delete 0x7000, probe 0x7000 -> delete drives bf_WE=1, bf_increment=0; elem_count goes 1→0; a delete at count 0 leaves count 0.
- Clear priority: clr_req and req0_valid both high in IDLE -> CLEAR entered; req0_ready=0; bf_rst_n low for 4 cycles; clr_done pulses once; elem_count=0; req0 is then granted.
- Reset mid-WAIT: rstb=1 during WAIT -> next edge: IDLE, resp_valid=0, elem_count=0, bf_rst_n=0 while rstb=1; no response emitted for the dropped request.
